uart_host_command_master: RTL

// Host-side peer of the FPGA's UART host interface: serialises a command
// ('L' frame) into ASCII-hex bytes and parses the FPGA's reply ('S' frame).

---
 rtl/uart_host_command_master_pkg.sv | 35 +++
 rtl/uart_host_command_master_if.sv | 43 ++++
 rtl/uart_hex_codec.sv | 27 ++
 rtl/uart_host_command_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_command_master_pkg.sv
// Shared constants, state encodings and helpers for the UART host command master.
package uart_host_command_master_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COUNT_W = 28;

  localparam logic [15:0] COMMAND_WRITE = 16'h0001;
  localparam logic [15:0] COMMAND_READ  = 16'h0002;

  localparam logic [7:0] CHAR_L          = 8'h4C;
  localparam logic [7:0] CHAR_S          = 8'h53;
  localparam logic [7:0] CHAR_0          = 8'h30;
  localparam logic [7:0] CHAR_A          = 8'h41;
  localparam logic [7:0] CHAR_HEX_OFFSET = 8'h37;  // 'A' - 10

  typedef struct packed {
    logic [WORD_W-1:0]  command;
    logic [WORD_W-1:0]  address;
    logic [COUNT_W-1:0] count;
  } cmd_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_SEND_L, TX_SEND_COUNT, TX_SEND_CMD, TX_SEND_ADDR, TX_GET_WORD, TX_SEND_DATA
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_COUNT, RX_STATUS, RX_ADDR, RX_DATA
  } rx_state_e;

  // A zero count still carries one data word.
  function automatic logic [COUNT_W-1:0] word_count(input logic [COUNT_W-1:0] count);
    return (count == '0) ? COUNT_W'(1) : count;
  endfunction

endpackage

// File: rtl/uart_host_command_master_if.sv
// Command, write-stream, byte-uart and response signals of the host command master.
interface uart_host_command_master_if;
  import uart_host_command_master_pkg::*;

  logic               i_cmd_en;
  logic               o_cmd_ready;
  logic [WORD_W-1:0]  i_cmd_command;
  logic [WORD_W-1:0]  i_cmd_address;
  logic [COUNT_W-1:0] i_cmd_data_count;
  logic [WORD_W-1:0]  i_wr_data;
  logic               i_wr_data_valid;
  logic               o_wr_data_ready;
  logic [7:0]         o_tx_byte;
  logic               o_tx_en;
  logic               i_tx_busy;
  logic [7:0]         i_rx_byte;
  logic               i_rx_available;
  logic [WORD_W-1:0]  o_rsp_status;
  logic [WORD_W-1:0]  o_rsp_address;
  logic [COUNT_W-1:0] o_rsp_data_count;
  logic [WORD_W-1:0]  o_rsp_data;
  logic               o_rsp_data_valid;
  logic               o_rsp_done;
  logic               o_rsp_error;
  logic               o_rsp_busy;

  modport master (
    input  i_cmd_en, i_cmd_command, i_cmd_address, i_cmd_data_count,
    input  i_wr_data, i_wr_data_valid, i_tx_busy, i_rx_byte, i_rx_available,
    output o_cmd_ready, o_wr_data_ready, o_tx_byte, o_tx_en,
    output o_rsp_status, o_rsp_address, o_rsp_data_count, o_rsp_data,
    output o_rsp_data_valid, o_rsp_done, o_rsp_error, o_rsp_busy
  );

  modport slave (
    output i_cmd_en, i_cmd_command, i_cmd_address, i_cmd_data_count,
    output i_wr_data, i_wr_data_valid, i_tx_busy, i_rx_byte, i_rx_available,
    input  o_cmd_ready, o_wr_data_ready, o_tx_byte, o_tx_en,
    input  o_rsp_status, o_rsp_address, o_rsp_data_count, o_rsp_data,
    input  o_rsp_data_valid, o_rsp_done, o_rsp_error, o_rsp_busy
  );

endinterface

// File: rtl/uart_hex_codec.sv
// Combinational uppercase ASCII-hex encoder and decoder.
module uart_hex_codec
  import uart_host_command_master_pkg::*;
(
  input  logic [3:0] enc_nibble,
  output logic [7:0] enc_char_c,
  input  logic [7:0] dec_char,
  output logic [3:0] dec_nibble_c,
  output logic       dec_illegal_c
);

  // Nibble to ASCII, ASCII to nibble; only '0'-'9' and 'A'-'F' decode as legal.
  always_comb begin
    enc_char_c    = (enc_nibble < 4'd10) ? 8'(CHAR_0 + 8'(enc_nibble))
                                         : 8'(CHAR_HEX_OFFSET + 8'(enc_nibble));
    dec_nibble_c  = 4'h0;
    dec_illegal_c = 1'b1;
    if (dec_char >= CHAR_0 && dec_char <= 8'(CHAR_0 + 8'd9)) begin
      dec_nibble_c  = 4'(dec_char - CHAR_0);
      dec_illegal_c = 1'b0;
    end else if (dec_char >= CHAR_A && dec_char <= 8'(CHAR_A + 8'd5)) begin
      dec_nibble_c  = 4'(dec_char - CHAR_HEX_OFFSET);
      dec_illegal_c = 1'b0;
    end
  end

endmodule

// File: rtl/uart_host_command_master.sv
// Serialises 'L' command frames to ASCII hex and parses 'S' reply frames; tx and rx independent.
module uart_host_command_master
  import uart_host_command_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50_000_000
) (
  input logic clk,
  input logic rst_n,
  uart_host_command_master_if.master bus
);

  // ---------------- tx path ----------------
  tx_state_e          tx_state_q, tx_state_d;
  cmd_t               cmd_q, cmd_d;
  logic               is_write_q, is_write_d;
  logic [COUNT_W-1:0] tx_left_q, tx_left_d;
  logic [WORD_W-1:0]  tx_sh_q, tx_sh_d;
  logic [2:0]         tx_nib_q, tx_nib_d;
  logic               tx_out_q, tx_out_d;
  logic               tx_seen_q, tx_seen_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_en_q, tx_en_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               wr_ready_q, wr_ready_d;
  logic               can_send, send;
  logic [7:0]         send_char, tx_char_c;
  logic [3:0]         tx_nib_unused;
  logic               tx_ill_unused;

  uart_hex_codec u_tx_codec (
    .enc_nibble    (tx_sh_q[31:28]),
    .enc_char_c    (tx_char_c),
    .dec_char      (8'h00),
    .dec_nibble_c  (tx_nib_unused),
    .dec_illegal_c (tx_ill_unused)
  );

  // Tx next state: one byte per free uart slot, MS nibble of the shift register first.
  always_comb begin
    tx_state_d  = tx_state_q;
    cmd_d       = cmd_q;
    is_write_d  = is_write_q;
    tx_left_d   = tx_left_q;
    tx_sh_d     = tx_sh_q;
    tx_nib_d    = tx_nib_q;
    tx_out_d    = tx_out_q;
    tx_seen_d   = tx_seen_q;
    tx_byte_d   = tx_byte_q;
    tx_en_d     = 1'b0;
    send        = 1'b0;
    send_char   = tx_char_c;
    can_send    = !bus.i_tx_busy && !tx_out_q;

    // A byte is outstanding until busy has risen and fallen again.
    if (tx_out_q) begin
      if (bus.i_tx_busy) begin
        tx_seen_d = 1'b1;
      end else if (tx_seen_q) begin
        tx_out_d  = 1'b0;
        tx_seen_d = 1'b0;
      end
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (bus.i_cmd_en) begin
          cmd_d      = '{command: bus.i_cmd_command, address: bus.i_cmd_address,
                         count: bus.i_cmd_data_count};
          is_write_d = (bus.i_cmd_command[15:0] == COMMAND_WRITE);
          tx_left_d  = is_write_d ? word_count(bus.i_cmd_data_count) : COUNT_W'(1);
          tx_state_d = TX_SEND_L;
        end
      end
      TX_SEND_L: begin
        if (can_send) begin
          send       = 1'b1;
          send_char  = CHAR_L;
          tx_sh_d    = {cmd_q.count, 4'h0};
          tx_nib_d   = 3'd0;
          tx_state_d = TX_SEND_COUNT;
        end
      end
      TX_SEND_COUNT, TX_SEND_CMD, TX_SEND_ADDR, TX_SEND_DATA: begin
        if (can_send) begin
          send     = 1'b1;
          tx_sh_d  = {tx_sh_q[27:0], 4'h0};
          tx_nib_d = 3'(tx_nib_q + 3'd1);
          if (tx_state_q == TX_SEND_COUNT && tx_nib_q == 3'd6) begin
            tx_sh_d    = cmd_q.command;
            tx_nib_d   = 3'd0;
            tx_state_d = TX_SEND_CMD;
          end else if (tx_state_q == TX_SEND_CMD && tx_nib_q == 3'd7) begin
            tx_sh_d    = cmd_q.address;
            tx_nib_d   = 3'd0;
            tx_state_d = TX_SEND_ADDR;
          end else if (tx_state_q == TX_SEND_ADDR && tx_nib_q == 3'd7) begin
            tx_nib_d   = 3'd0;
            tx_state_d = TX_GET_WORD;
          end else if (tx_state_q == TX_SEND_DATA && tx_nib_q == 3'd7) begin
            tx_nib_d = 3'd0;
            if (tx_left_q == COUNT_W'(1)) begin
              tx_state_d = TX_IDLE;
            end else begin
              tx_left_d  = COUNT_W'(tx_left_q - COUNT_W'(1));
              tx_state_d = TX_GET_WORD;
            end
          end
        end
      end
      TX_GET_WORD: begin
        if (!is_write_q) begin
          tx_sh_d    = '0;
          tx_nib_d   = 3'd0;
          tx_state_d = TX_SEND_DATA;
        end else if (wr_ready_q && bus.i_wr_data_valid) begin
          tx_sh_d    = bus.i_wr_data;
          tx_nib_d   = 3'd0;
          tx_state_d = TX_SEND_DATA;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (send) begin
      tx_en_d   = 1'b1;
      tx_byte_d = send_char;
      tx_out_d  = 1'b1;
      tx_seen_d = 1'b0;
    end
    cmd_ready_d = (tx_state_d == TX_IDLE);
    wr_ready_d  = (tx_state_d == TX_GET_WORD) && is_write_d;
  end

  // Tx state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      cmd_q       <= '0;
      is_write_q  <= 1'b0;
      tx_left_q   <= '0;
      tx_sh_q     <= '0;
      tx_nib_q    <= '0;
      tx_out_q    <= 1'b0;
      tx_seen_q   <= 1'b0;
      tx_byte_q   <= '0;
      tx_en_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      cmd_q       <= cmd_d;
      is_write_q  <= is_write_d;
      tx_left_q   <= tx_left_d;
      tx_sh_q     <= tx_sh_d;
      tx_nib_q    <= tx_nib_d;
      tx_out_q    <= tx_out_d;
      tx_seen_q   <= tx_seen_d;
      tx_byte_q   <= tx_byte_d;
      tx_en_q     <= tx_en_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // ---------------- rx path ----------------
  rx_state_e          rx_state_q, rx_state_d;
  logic [WORD_W-1:0]  rx_sh_q, rx_sh_d;
  logic [2:0]         rx_nib_q, rx_nib_d;
  logic [COUNT_W-1:0] rx_left_q, rx_left_d;
  logic [31:0]        tmo_q, tmo_d;
  logic [WORD_W-1:0]  status_q, status_d, addr_q, addr_d, data_q, data_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               valid_q, valid_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [3:0]         rx_nib_c;
  logic               rx_ill_c;
  logic [WORD_W-1:0]  rx_word;
  logic [7:0]         rx_char_unused;

  uart_hex_codec u_rx_codec (
    .enc_nibble    (4'h0),
    .enc_char_c    (rx_char_unused),
    .dec_char      (bus.i_rx_byte),
    .dec_nibble_c  (rx_nib_c),
    .dec_illegal_c (rx_ill_c)
  );

  assign rx_word = {rx_sh_q[27:0], rx_nib_c};

  // Rx next state: accumulate nibbles per field, strobe data/done/error.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_nib_d   = rx_nib_q;
    rx_left_d  = rx_left_q;
    tmo_d      = tmo_q;
    status_d   = status_q;
    addr_d     = addr_q;
    count_d    = count_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (rx_state_q == RX_IDLE) begin
      tmo_d = '0;
      if (bus.i_rx_available && bus.i_rx_byte == CHAR_S) begin
        rx_sh_d    = '0;
        rx_nib_d   = 3'd0;
        rx_state_d = RX_COUNT;
      end
    end else if (bus.i_rx_available) begin
      tmo_d = '0;
      if (rx_ill_c) begin
        err_d      = 1'b1;
        rx_state_d = RX_IDLE;
      end else begin
        rx_sh_d  = rx_word;
        rx_nib_d = 3'(rx_nib_q + 3'd1);
        case (rx_state_q)
          RX_COUNT: if (rx_nib_q == 3'd6) begin
            count_d    = rx_word[COUNT_W-1:0];
            rx_left_d  = word_count(rx_word[COUNT_W-1:0]);
            rx_nib_d   = 3'd0;
            rx_state_d = RX_STATUS;
          end
          RX_STATUS: if (rx_nib_q == 3'd7) begin
            status_d   = rx_word;
            rx_state_d = RX_ADDR;
          end
          RX_ADDR: if (rx_nib_q == 3'd7) begin
            addr_d     = rx_word;
            rx_state_d = RX_DATA;
          end
          RX_DATA: if (rx_nib_q == 3'd7) begin
            data_d  = rx_word;
            valid_d = 1'b1;
            if (rx_left_q == COUNT_W'(1)) begin
              done_d     = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              rx_left_d = COUNT_W'(rx_left_q - COUNT_W'(1));
            end
          end
          default: rx_state_d = RX_IDLE;
        endcase
      end
    end else if (TIMEOUT_CYCLES != 0 && tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
      tmo_d      = '0;
      err_d      = 1'b1;
      rx_state_d = RX_IDLE;
    end else begin
      tmo_d = 32'(tmo_q + 32'd1);
    end
    busy_d = (rx_state_d != RX_IDLE);
  end

  // Rx state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_sh_q    <= '0;
      rx_nib_q   <= '0;
      rx_left_q  <= '0;
      tmo_q      <= '0;
      status_q   <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sh_q    <= rx_sh_d;
      rx_nib_q   <= rx_nib_d;
      rx_left_q  <= rx_left_d;
      tmo_q      <= tmo_d;
      status_q   <= status_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_cmd_ready      = cmd_ready_q;
  assign bus.o_wr_data_ready  = wr_ready_q;
  assign bus.o_tx_byte        = tx_byte_q;
  assign bus.o_tx_en          = tx_en_q;
  assign bus.o_rsp_status     = status_q;
  assign bus.o_rsp_address    = addr_q;
  assign bus.o_rsp_data_count = count_q;
  assign bus.o_rsp_data       = data_q;
  assign bus.o_rsp_data_valid = valid_q;
  assign bus.o_rsp_done       = done_q;
  assign bus.o_rsp_error      = err_q;
  assign bus.o_rsp_busy       = busy_q;

endmodule
